cache_fill_fsm: RTL and testbench

- Miss-handling controller between the fetch/memory stage and the multi-cycle main memory, for the Phase 3 cached design.
- When the cache lookup reports a miss, it stalls the pipeline and streams one 16-byte block from memory into the cache data array, one word per return.
- On the final word it writes the tag array.
- One instance serves the I-cache and one serves the D-cache.

---
 rtl/cache_fill_fsm_pkg.sv | 20 ++
 rtl/cache_fill_fsm_counter.sv | 28 ++
 rtl/cache_fill_fsm.sv | 133 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants, FSM state type and block alignment helper for the cache fill controller.
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_BYTES     = 2 * WORDS_PER_BLOCK;
    localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK);
    localparam int ADDR_W          = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    function automatic logic [ADDR_W-1:0] block_base(
        input logic [ADDR_W-1:0] addr
    );
        return addr & ~ADDR_W'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating word counter with clear/increment and an async active-high reset.
module fill_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         done
);

    localparam logic [W-1:0] MAX = W'(LIMIT);

    assign done = (cnt == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline and streams one block into the cache.
// Define CACHE_FILL_CRIT_WORD_EN for critical-word-first issue order and crit_word_valid.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int OFFSET_W        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_address,
    output logic                fsm_busy,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_data_valid,
    input  logic [15:0]         mem_data,
    output logic                write_data_array,
    output logic [OFFSET_W-1:0] data_word_sel,
    output logic [15:0]         data_wr,
    output logic                write_tag_array,
    output logic                crit_word_valid
);

    import cache_pkg::*;

    localparam int CW = OFFSET_W + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    fill_state_t state, state_nxt;

    logic [ADDR_W-1:0]   base;
    logic [CW-1:0]       issue_cnt, ret_cnt;
    logic                issue_done, ret_done;
    logic                start;
    logic [OFFSET_W-1:0] issue_idx, ret_idx;

    assign start = (state == IDLE) && miss_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
        end else if (start) begin
            base <= miss_address & ALIGN;
        end
    end

`ifdef CACHE_FILL_CRIT_WORD_EN
    logic [OFFSET_W-1:0] crit_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crit_w <= '0;
        end else if (start) begin
            crit_w <= miss_address[OFFSET_W:1];
        end
    end

    // Word order rotates from the missing word and wraps inside the block
    assign issue_idx = OFFSET_W'(CW'(crit_w) + issue_cnt);
    assign ret_idx   = OFFSET_W'(CW'(crit_w) + ret_cnt);
    assign crit_word_valid = write_data_array && (ret_cnt == '0);
`else
    assign issue_idx = OFFSET_W'(issue_cnt);
    assign ret_idx   = OFFSET_W'(ret_cnt);
    assign crit_word_valid = 1'b0;
`endif

    fill_counter #(
        .W     (CW),
        .LIMIT (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .inc  (mem_req),
        .cnt  (issue_cnt),
        .done (issue_done)
    );

    fill_counter #(
        .W     (CW),
        .LIMIT (WORDS_PER_BLOCK)
    ) u_ret_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .inc  (write_data_array),
        .cnt  (ret_cnt),
        .done (ret_done)
    );

    always_comb begin
        state_nxt        = state;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        unique case (state)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                fsm_busy         = 1'b1;
                mem_req          = !issue_done;
                write_data_array = mem_data_valid && !ret_done;
                if (write_data_array && (ret_cnt == LAST)) begin
                    write_tag_array = 1'b1;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr = mem_req
                    ? base + ADDR_W'({issue_idx, 1'b0})
                    : '0;
    assign data_word_sel = write_data_array ? ret_idx : '0;
    assign data_wr       = write_data_array ? mem_data : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: vector table, directed corner sequences and a
// randomized run against a fill-schedule model with a 4-cycle memory.
module tb_cache_fill_fsm;

`ifdef CACHE_FILL_CRIT_WORD_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        write_data_array;
    logic [2:0]  data_word_sel;
    logic [15:0] data_wr;
    logic        write_tag_array;
    logic        crit_word_valid;

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_data_valid   (mem_data_valid),
        .mem_data         (mem_data),
        .write_data_array (write_data_array),
        .data_word_sel    (data_word_sel),
        .data_wr          (data_wr),
        .write_tag_array  (write_tag_array),
        .crit_word_valid  (crit_word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    typedef struct {
        bit          miss;
        logic [15:0] addr;
        bit          busy;
        bit          req;
        logic [15:0] maddr;
        bit          wr;
        logic [2:0]  sel;
        logic [15:0] data;
        bit          tag;
        bit          crit;
    } vec_t;

    rsp_t q[$];
    vec_t tbl[14];
    int   ord[8];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          fill_start = -100;
    int          fill_w  = 0;
    logic [15:0] fill_base = '0;

    logic        s_busy, s_req, s_wr, s_tag, s_crit;
    logic [15:0] s_addr, s_data;
    logic [2:0]  s_sel;

    function automatic logic [15:0] resp(input logic [15:0] a);
        return 16'hA000 + {13'd0, a[3:1]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit miss, input logic [15:0] a,
                        input bit spur, input bit use_model);
        bit          busy_prev, inf, e_req, e_wr;
        int          d;
        logic [15:0] e_addr, e_data;
        logic [2:0]  e_sel;
        rsp_t        e;
        @(posedge clk);
        #1;
        busy_prev = (fill_start >= 0) && (cyc > fill_start)
                  && (cyc <= fill_start + 12);
        rst            = r;
        miss_detected  = miss && !r;
        miss_address   = a;
        mem_data_valid = 1'b0;
        mem_data       = '0;
        if (r) q.delete();
        if (q.size() > 0 && q[0].due == cyc) begin
            mem_data_valid = 1'b1;
            mem_data       = q[0].data;
            void'(q.pop_front());
        end else if (spur && !busy_prev) begin
            mem_data_valid = 1'b1;
            mem_data       = 16'($urandom);
        end
        if (r) begin
            fill_start = -100;
        end else if (miss && !busy_prev) begin
            fill_start = cyc;
            fill_base  = a & 16'hFFF0;
            fill_w     = CRIT ? int'(a[3:1]) : 0;
        end
        @(negedge clk);
        s_busy = fsm_busy;  s_req  = mem_req;  s_addr = mem_addr;
        s_wr   = write_data_array; s_sel = data_word_sel;
        s_data = data_wr;   s_tag  = write_tag_array;
        s_crit = crit_word_valid;
        if (mem_req) begin
            e.due  = cyc + 4;
            e.data = resp(mem_addr);
            q.push_back(e);
        end
        if (use_model) begin
            d      = cyc - fill_start;
            inf    = !r && (fill_start >= 0) && (d >= 0) && (d <= 12);
            e_req  = inf && (d >= 1) && (d <= 8);
            e_wr   = inf && (d >= 5);
            e_addr = '0;
            e_sel  = '0;
            e_data = '0;
            if (e_req) e_addr = fill_base + 16'(2 * ((fill_w + d - 1) % 8));
            if (e_wr) begin
                e_sel  = 3'((fill_w + d - 5) % 8);
                e_data = resp(fill_base + 16'(2 * e_sel));
            end
            chk("busy", s_busy, inf);
            chk("mem_req", s_req, e_req);
            chk("mem_addr", s_addr, e_addr);
            chk("wr_data", s_wr, e_wr);
            chk("word_sel", s_sel, e_sel);
            chk("data_wr", s_data, e_data);
            chk("tag", s_tag, inf && (d == 12));
            chk("crit", s_crit, CRIT && inf && (d == 5));
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 1);
    endtask

    initial begin
        logic [15:0] ma;
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = '0;
        mem_data_valid = 1'b0;
        mem_data = '0;

        step(1, 0, 16'h0, 0, 1);
        step(1, 0, 16'h0, 0, 1);
        idle(5);

        if (CRIT) begin
            ord = '{5, 6, 7, 0, 1, 2, 3, 4};
            ma  = 16'h123A;
        end else begin
            ord = '{0, 1, 2, 3, 4, 5, 6, 7};
            ma  = 16'h1236;
        end
        for (int c = 0; c < 14; c++) begin
            tbl[c].miss  = (c == 0);
            tbl[c].addr  = (c == 0) ? ma : 16'h0;
            tbl[c].busy  = (c <= 12);
            tbl[c].req   = (c >= 1) && (c <= 8);
            tbl[c].maddr = '0;
            tbl[c].wr    = (c >= 5) && (c <= 12);
            tbl[c].sel   = '0;
            tbl[c].data  = '0;
            tbl[c].tag   = (c == 12);
            tbl[c].crit  = CRIT && (c == 5);
            if (tbl[c].req) tbl[c].maddr = 16'h1230 + 16'(2 * ord[c-1]);
            if (tbl[c].wr) begin
                tbl[c].sel  = 3'(ord[c-5]);
                tbl[c].data = 16'hA000 + 16'(ord[c-5]);
            end
        end
        for (int c = 0; c < 14; c++) begin
            step(0, tbl[c].miss, tbl[c].addr, 0, 0);
            chk("tbl_busy", s_busy, tbl[c].busy);
            chk("tbl_req", s_req, tbl[c].req);
            chk("tbl_addr", s_addr, tbl[c].maddr);
            chk("tbl_wr", s_wr, tbl[c].wr);
            chk("tbl_sel", s_sel, tbl[c].sel);
            chk("tbl_data", s_data, tbl[c].data);
            chk("tbl_tag", s_tag, tbl[c].tag);
            chk("tbl_crit", s_crit, tbl[c].crit);
        end
        idle(3);

        step(0, 1, 16'h1236, 0, 1);
        idle(5);
        step(0, 1, 16'h4000, 0, 1);
        idle(6);
        step(0, 1, 16'h4000, 0, 1);
        idle(15);

        step(0, 1, 16'h2346, 0, 1);
        idle(6);
        step(1, 0, 16'h0, 0, 1);
        step(1, 0, 16'h0, 0, 1);
        idle(3);
        step(0, 1, 16'h5550, 0, 1);
        idle(15);

        step(0, 1, 16'hFFFA, 0, 1);
        idle(15);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 5) == 0,
                 16'($urandom), ($urandom % 4) == 0, 1);
        end
        idle(15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
